snitch_perf_sampler: RTL
========================

Name: snitch_perf_sampler

Overview:
Periodic sampling controller for the cluster performance-counter bank. On a programmable cycle interval it snapshots all counters atomically, then serialises them onto a valid/ready stream toward a trace sink (DMA or trace FIFO). It sits beside the cluster peripheral: counters in, stream out, configuration from peripheral registers. Bursts missed because the stream was still busy are counted, never queued.

Parameters:
NumPerfCounters, 16, number of counters in the bank (>=1)
CounterWidth, 48, width of each counter value
IntervalWidth, 32, width of the sampling-interval field
DropCntWidth, 16, width of the dropped-burst counter
IdxWidth, $clog2(NumPerfCounters) (min 1), derived, do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  sampling enable (level)
interval_i  in  IntervalWidth  cycles between sample ticks; 0 = sampling disabled
perf_counter_i  in  NumPerfCounters*CounterWidth  live counter values
sample_valid_o  out  1  stream beat valid
sample_ready_i  in  1  stream beat accepted when valid&ready
sample_data_o  out  CounterWidth  snapshot value of counter sample_idx_o
sample_idx_o  out  IdxWidth  counter index of current beat
sample_last_o  out  1  final beat of a burst (idx == NumPerfCounters-1)
sample_seq_o  out  16  burst sequence number, wraps 0xFFFF->0
busy_o  out  1  high in SNAP or EMIT
dropped_o  out  DropCntWidth  ticks lost while a burst was in progress (saturating)
clear_dropped_i  in  1  synchronous clear of dropped_o

Behaviour:
- Reset: state IDLE; all outputs 0; timer, seq, dropped, snapshot cleared.
- States: IDLE, WAIT, SNAP, EMIT.
- IDLE -> WAIT when enable_i && interval_i!=0; timer loaded with interval_i-1.
- WAIT: timer decrements each cycle; at 0 a tick occurs -> SNAP, timer reloaded from current interval_i-1 (interval_i resampled at every reload). enable_i==0 or interval_i==0 in WAIT -> IDLE same cycle.
- Timer keeps running in SNAP/EMIT (fixed cadence, no drift).
- SNAP (1 cycle): all perf_counter_i captured into snapshot registers in the same edge; idx=0. -> EMIT.
- EMIT: sample_valid_o=1, data=snapshot[idx]. Beat handshake on valid&ready: idx++. On last-beat handshake: seq++, -> WAIT if enable_i && interval_i!=0, else IDLE. Tick first observed visible 1 cycle after tick (SNAP-to-first-valid latency 1 cycle; tick-to-valid 2 cycles).
- Stream rules: once valid asserted, valid/data/idx/last held stable until handshake; enable_i deassertion never aborts a burst in progress.
- Tick during SNAP or EMIT: burst not restarted, dropped_o += 1 (saturate at all-ones). If the tick coincides with the last-beat handshake, it is NOT dropped: next state SNAP directly.
- clear_dropped_i has priority over a simultaneous drop increment (result 0).
- Snapshot holds values from the SNAP cycle; counter changes during EMIT are invisible.
- NumPerfCounters==1: every beat has last=1.
- Async reset mid-EMIT: valid drops immediately, burst discarded, seq reset to 0.

Decomposition:
- snitch_perf_sampler_pkg: state enum (IDLE/WAIT/SNAP/EMIT), beat struct {data, idx, last, seq}.
- Sub-module snitch_perf_sampler_timer: reloadable down-counter producing a 1-cycle tick, with load/run/reload-value inputs.
- Top: FSM, snapshot register file, beat mux, seq and drop counters.

Test Plan:
- N=4, interval=10, ready=1: valid rises 2 cycles after each tick; 4 beats idx 0..3, last on idx 3, seq 0 then 1; next burst starts 10 cycles after previous tick.
- Counters incrementing every cycle, ready=0 for 5 cycles after SNAP: every beat data equals the SNAP-cycle value; valid/data stable during stall.
- interval=3, ready held 0 for 20 cycles: dropped_o=6 after release, single burst emitted; seq increments by 1 only.
- Tick coincident with last-beat handshake: no drop, SNAP next cycle, seq continuous.
- enable_i low mid-EMIT: burst completes all 4 beats, then IDLE, busy_o=0; interval=0 with enable=1 stays IDLE.
- rst_ni asserted mid-EMIT (idx=2): valid=0 immediately, seq=0, dropped=0; dropped at 0xFFFF plus drop stays 0xFFFF, clear_dropped_i -> 0.

Source files
------------

// File: rtl/snitch_perf_sampler_pkg.sv
// Shared types for the performance-counter sampler: FSM encoding, sequence width
// and the helper that sizes the beat index.
package snitch_perf_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SNAP = 2'd2,
        EMIT = 2'd3
    } state_e;

    localparam int unsigned SeqWidth = 16;

    // A one-counter bank still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snitch_perf_sampler_timer.sv
// Reloadable down-counter. tick_o is high for the single cycle in which a running
// count sits at zero; that same edge reloads the count so the cadence never drifts.
module snitch_perf_sampler_timer #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [Width-1:0] reload_i,
    output logic             tick_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || tick_o) begin
            cnt_d = reload_i;
        end else if (run_i) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snitch_perf_sampler.sv
// Periodic snapshot of the perf-counter bank, serialised one counter per beat on a
// valid/ready stream. Ticks arriving while a burst is in flight are only counted.
module snitch_perf_sampler
    import snitch_perf_sampler_pkg::*;
#(
    parameter int unsigned NumPerfCounters = 16,
    parameter int unsigned CounterWidth    = 48,
    parameter int unsigned IntervalWidth   = 32,
    parameter int unsigned DropCntWidth    = 16,
    parameter int unsigned IdxWidth        = idx_width(NumPerfCounters)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    enable_i,
    input  logic [IntervalWidth-1:0]                interval_i,
    input  logic [NumPerfCounters*CounterWidth-1:0] perf_counter_i,
    output logic                                    sample_valid_o,
    input  logic                                    sample_ready_i,
    output logic [CounterWidth-1:0]                 sample_data_o,
    output logic [IdxWidth-1:0]                     sample_idx_o,
    output logic                                    sample_last_o,
    output logic [SeqWidth-1:0]                     sample_seq_o,
    output logic                                    busy_o,
    output logic [DropCntWidth-1:0]                 dropped_o,
    input  logic                                    clear_dropped_i
);

    typedef struct packed {
        logic [CounterWidth-1:0] data;
        logic [IdxWidth-1:0]     idx;
        logic                    last;
        logic [SeqWidth-1:0]     seq;
    } beat_t;

    state_e                                      state_q;
    logic [IdxWidth-1:0]                         idx_q;
    logic [SeqWidth-1:0]                         seq_q;
    logic [DropCntWidth-1:0]                     dropped_q;
    logic [NumPerfCounters-1:0][CounterWidth-1:0] snap_q;

    logic  go, tick, hs, last_beat, last_hs, drop;
    beat_t beat;

    assign go        = enable_i && (interval_i != '0);
    assign hs        = (state_q == EMIT) && sample_ready_i;
    assign last_beat = (idx_q == IdxWidth'(NumPerfCounters - 1));
    assign last_hs   = hs && last_beat;
    // A tick landing on the closing handshake rolls straight into the next burst.
    assign drop      = tick && ((state_q == SNAP) || ((state_q == EMIT) && !last_hs));

    snitch_perf_sampler_timer #(
        .Width (IntervalWidth)
    ) i_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   ((state_q == IDLE) && go),
        .run_i    (state_q != IDLE),
        .reload_i (interval_i - IntervalWidth'(1)),
        .tick_o   (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seq_q     <= '0;
            dropped_q <= '0;
        end else begin
            if (clear_dropped_i) begin
                dropped_q <= '0;
            end else if (drop && (dropped_q != '1)) begin
                dropped_q <= dropped_q + DropCntWidth'(1);
            end

            unique case (state_q)
                IDLE: if (go) state_q <= WAIT;
                WAIT: begin
                    if (!go) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        state_q <= SNAP;
                    end
                end
                SNAP: begin
                    idx_q   <= '0;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (hs) begin
                        if (last_beat) begin
                            idx_q <= '0;
                            seq_q <= seq_q + SeqWidth'(1);
                            if (go && tick) begin
                                state_q <= SNAP;
                            end else if (go) begin
                                state_q <= WAIT;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + IdxWidth'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Whole bank is latched on one edge so a burst is a coherent snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
        end else if (state_q == SNAP) begin
            snap_q <= perf_counter_i;
        end
    end

    always_comb begin
        beat = '0;
        if (state_q == EMIT) begin
            beat.data = snap_q[idx_q];
            beat.idx  = idx_q;
            beat.last = last_beat;
        end
        beat.seq = seq_q;
    end

    assign sample_valid_o = (state_q == EMIT);
    assign sample_data_o  = beat.data;
    assign sample_idx_o   = beat.idx;
    assign sample_last_o  = beat.last;
    assign sample_seq_o   = beat.seq;
    assign busy_o         = (state_q == SNAP) || (state_q == EMIT);
    assign dropped_o      = dropped_q;

endmodule
